// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block family: data width, pointer width,
// the skid buffer occupancy encoding and the default data word type.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_PTR_W  = 3;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    typedef logic [FIFO_DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer with an occupancy FSM.
//   clk, rstn  : clock, async active-low reset
//   flush      : synchronous discard of both entries
//   push       : write push_data this cycle (caller guarantees room)
//   push_data  : word being written
//   pop        : head is consumed this cycle (only asserted when occ != S_EMPTY)
//   occ        : current occupancy
//   head       : oldest buffered word, drives the output stream
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output occ_e              occ,
    output logic [DATA_W-1:0] head
);

    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            occ_d = S_EMPTY;
        end else begin
            case (occ_q)
                S_EMPTY: begin
                    if (push) begin
                        head_d = push_data;
                        occ_d  = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_d = push_data;
                    end else if (push) begin
                        skid_d = push_data;
                        occ_d  = S_TWO;
                    end else if (pop) begin
                        occ_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // Skid always moves forward on a pop; a simultaneous
                    // push refills it so occupancy stays at two.
                    if (pop) begin
                        head_d = skid_q;
                        if (push) skid_d = push_data;
                        else      occ_d  = S_ONE;
                    end
                end
                default: occ_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q  <= S_EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

    // A push into a full buffer without a pop would overwrite skid.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(occ_q == S_TWO && push && !pop && !flush));

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine for the synchronous fifo block. Issues pops only when the
// buffer can absorb the word returning one cycle later and re-presents the
// words on a valid/ready stream through a two-entry skid buffer.
//   clk, rstn  : clock, async active-low reset
//   fifo_empty : empty flag from the fifo
//   fifo_data  : fifo data_out, valid the cycle after a sampled fifo_rd
//   fifo_rd    : combinational pop request to the fifo
//   flush      : synchronous discard of buffered and in-flight words
//   m_valid/m_ready/m_data : output stream
//   pop_cnt    : completed output handshakes, wrapping
//   busy       : buffer non-empty or a read in flight
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  pop_cnt,
    output logic              busy
);

    occ_e             occ;
    logic             pop;
    logic             land;
    logic [2:0]       fill;
    logic             inflight_q, inflight_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

    assign m_valid = (occ != S_EMPTY);
    assign pop     = m_valid && m_ready;
    assign land    = inflight_q && !drop_q;

    // Committed slots: buffered words plus the one still coming back.
    assign fill    = 3'(occ) + 3'(inflight_q);

    // At two committed slots a read is only safe if a pop frees one now.
    assign fifo_rd = rstn && !flush && !fifo_empty &&
                     ((fill < 3'd2) || (fill == 3'd2 && pop));

    always_comb begin
        inflight_d = fifo_rd;
        drop_d     = flush && inflight_q;
        pop_cnt_d  = pop_cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            pop_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    fifo_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .push      (land),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head      (m_data)
    );

    assign pop_cnt = pop_cnt_q;
    assign busy    = m_valid || inflight_q;

endmodule
